// File: rtl/vanity_search_engine.sv
// vanity_search_engine: multi-lane masked hash-pattern key search with result FIFO
module vanity_search_engine #(
  parameter int NUM_LANES    = 4,
  parameter int KEY_WIDTH    = 256,
  parameter int HASH_WIDTH   = 256,
  parameter int HASH_LATENCY = 2,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            start,
  input  logic                                            stop,
  input  logic                                            first_only,
  input  logic [KEY_WIDTH-1:0]                            base_key,
  input  logic [31:0]                                     num_rounds,
  input  logic [HASH_WIDTH-1:0]                           pattern,
  input  logic [HASH_WIDTH-1:0]                           pattern_mask,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            result_valid,
  input  logic                                            result_ready,
  output logic [KEY_WIDTH-1:0]                            result_key,
  output logic [(NUM_LANES > 1 ? $clog2(NUM_LANES) : 1)-1:0] result_lane,
  output logic [31:0]                                     keys_tested,
  output logic [15:0]                                     drop_count,
  output logic                                            overflow
);
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int AW = RESULT_DEPTH > 1 ? $clog2(RESULT_DEPTH) : 1;
  localparam int CW = $clog2(NUM_LANES + 1);
  localparam int EW = KEY_WIDTH + LW;
  localparam logic [HASH_WIDTH-1:0] C = {(HASH_WIDTH/32){32'hDEADBEEF}};
  localparam logic [1:0] IDLE = 2'd0, SEARCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [1:0]                               state_q, state_d;
  logic                                     fo_q, fo_d, pushed_q, pushed_d, ovf_q, ovf_d;
  logic [31:0]                              nr_q, nr_d, round_q, round_d, keys_q, keys_d;
  logic [HASH_WIDTH-1:0]                    pat_q, pat_d, mask_q, mask_d;
  logic [KEY_WIDTH-1:0]                     nk_q, nk_d;
  logic [HASH_LATENCY-1:0]                  valid_q, valid_d;
  logic [HASH_LATENCY-1:0][KEY_WIDTH-1:0]   key_q, key_d;
  logic [RESULT_DEPTH-1:0][EW-1:0]          mem_q, mem_d;
  logic [AW-1:0]                            wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]                              cnt_q, cnt_d;
  logic [15:0]                              drop_q, drop_d;
  logic                                     ev, any, pop, can_push, silent, push, issue;
  logic [KEY_WIDTH-1:0]                     ek;
  logic [NUM_LANES-1:0]                     match;
  logic [LW-1:0]                            sel;
  logic [CW-1:0]                            nmatch, ndrop;
  logic [16:0]                              drop_sum;
  logic [EW-1:0]                            head;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(RESULT_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Evaluate the last pipeline stage: per-lane match, lowest-lane select and push/drop decision
  always_comb begin
    ev = valid_q[HASH_LATENCY-1];
    ek = key_q[HASH_LATENCY-1];
    match = '0;
    sel = '0;
    nmatch = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      match[i] = ev && (((((ek + KEY_WIDTH'(i)) ^ C) ^ pat_q) & mask_q) == '0);
      if (match[i]) sel = LW'(i);
      nmatch = nmatch + CW'(match[i]);
    end
    any = |match;
    pop = (cnt_q != '0) && result_ready;
    can_push = (cnt_q != (AW+1)'(RESULT_DEPTH)) || pop;
    silent = fo_q && pushed_q;
    push = any && can_push && !silent;
    ndrop = (silent || !any) ? '0 : push ? (fo_q ? '0 : nmatch - 1'b1) : nmatch;
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
  end

  // Control FSM, round issue, pipeline advance, FIFO and statistics
  always_comb begin
    state_d = state_q;
    fo_d = fo_q;
    nr_d = nr_q;
    pat_d = pat_q;
    mask_d = mask_q;
    nk_d = nk_q;
    round_d = round_q;
    issue = 1'b0;
    if (state_q == IDLE && start) begin
      fo_d = first_only;
      nr_d = num_rounds;
      pat_d = pattern;
      mask_d = pattern_mask;
      nk_d = base_key;
      round_d = '0;
      state_d = SEARCH;
    end else if (state_q == SEARCH) begin
      if (round_q < nr_q && !stop && !(fo_q && pushed_q)) begin
        issue = 1'b1;
        round_d = round_q + 1'b1;
        nk_d = nk_q + KEY_WIDTH'(NUM_LANES);
      end else state_d = DRAIN;
    end else if (state_q == DRAIN) begin
      if (valid_q == '0) state_d = DONE;
    end else if (state_q == DONE) state_d = IDLE;
    valid_d[0] = issue;
    key_d[0] = nk_q;
    for (int s = 1; s < HASH_LATENCY; s++) begin
      valid_d[s] = valid_q[s-1];
      key_d[s] = key_q[s-1];
    end
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {ek + KEY_WIDTH'(sel), sel};
    wr_d = push ? inc(wr_q) : wr_q;
    rd_d = pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    pushed_d = pushed_q | push;
    keys_d = ev ? keys_q + 32'(NUM_LANES) : keys_q;
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d = ovf_q | (ndrop != '0);
    if (state_q == IDLE && start) begin
      pushed_d = 1'b0;
      keys_d = '0;
      drop_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fo_q <= 1'b0;
      nr_q <= '0;
      pat_q <= '0;
      mask_q <= '0;
      nk_q <= '0;
      round_q <= '0;
      valid_q <= '0;
      key_q <= '0;
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      pushed_q <= 1'b0;
      keys_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fo_q <= fo_d;
      nr_q <= nr_d;
      pat_q <= pat_d;
      mask_q <= mask_d;
      nk_q <= nk_d;
      round_q <= round_d;
      valid_q <= valid_d;
      key_q <= key_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      pushed_q <= pushed_d;
      keys_q <= keys_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end

  assign head = mem_q[rd_q];
  assign busy = (state_q == SEARCH) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign result_valid = cnt_q != '0;
  assign result_key = result_valid ? head[EW-1:LW] : '0;
  assign result_lane = result_valid ? head[LW-1:0] : '0;
  assign keys_tested = keys_q;
  assign drop_count = drop_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_vanity_search_engine.sv
// tb_vanity_search_engine: directed scoreboard bench for vanity_search_engine
module tb_vanity_search_engine;
  localparam logic [255:0] C = {8{32'hDEADBEEF}};
  localparam logic [255:0] ONES = '1;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, first_only = 1'b0;
  logic [255:0] base_key = '0, pattern = '0, pattern_mask = '0;
  logic [31:0] num_rounds = '0;
  logic busy, done, result_valid, result_ready = 1'b1, overflow;
  logic [255:0] result_key;
  logic [1:0] result_lane;
  logic [31:0] keys_tested;
  logic [15:0] drop_count;

  typedef struct { logic [255:0] key; logic [1:0] lane; } exp_t;
  exp_t exp_q[$];
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0;

  vanity_search_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .first_only(first_only),
    .base_key(base_key), .num_rounds(num_rounds), .pattern(pattern), .pattern_mask(pattern_mask),
    .busy(busy), .done(done), .result_valid(result_valid), .result_ready(result_ready),
    .result_key(result_key), .result_lane(result_lane), .keys_tested(keys_tested),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted result is compared against the queue head
  always @(negedge clk) begin
    if (reset_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got key %0h lane %0d required none", result_key, result_lane);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_key", result_key, e.key);
        chk("result_lane", 256'(result_lane), 256'(e.lane));
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic expect_res(input logic [255:0] k, input logic [1:0] l);
    exp_t e;
    e.key = k;
    e.lane = l;
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic [255:0] b, input logic [31:0] n, input logic [255:0] p,
                        input logic [255:0] m, input logic f);
    @(posedge clk); #1;
    base_key = b; num_rounds = n; pattern = p; pattern_mask = m; first_only = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    bit seen = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      seen = done;
    end
    total_cnt++;
    if (seen) pass_cnt++;
    else $display("FAIL %s: got no done pulse within %0d cycles required done", name, budget);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 256'(done), 256'(0));
    chk({name, "_busy_after"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int k;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 256'(busy), 0);
    chk("rst_done", 256'(done), 0);
    chk("rst_valid", 256'(result_valid), 0);
    chk("rst_keys", 256'(keys_tested), 0);
    chk("rst_drop", 256'(drop_count), 0);
    chk("rst_ovf", 256'(overflow), 0);
    chk("rst_key", result_key, 0);

    // 1: single exact match at key 5
    d0 = done_cnt;
    expect_res(256'd5, 2'd1);
    launch(256'd0, 32'd8, C ^ 256'd5, ONES, 1'b0);
    chk("t1_busy", 256'(busy), 1);
    wait_done(40, "t1");
    chk("t1_keys", 256'(keys_tested), 32);
    chk("t1_drop", 256'(drop_count), 0);
    chk("t1_ovf", 256'(overflow), 0);
    repeat (3) @(posedge clk);
    #1 chk("t1_done_count", 256'(done_cnt), 256'(d0 + 1));
    chk("t1_sb_empty", 256'(exp_q.size()), 0);

    // 2: mask 0, consumer stalled, FIFO keeps lane-0 keys and drops the rest
    result_ready = 1'b0;
    expect_res(256'd0, 2'd0);
    expect_res(256'd4, 2'd0);
    expect_res(256'd8, 2'd0);
    launch(256'd0, 32'd3, 256'd0, 256'd0, 1'b0);
    wait_done(20, "t2");
    chk("t2_drop", 256'(drop_count), 9);
    chk("t2_ovf", 256'(overflow), 1);
    chk("t2_keys", 256'(keys_tested), 12);
    chk("t2_valid_held", 256'(result_valid), 1);
    chk("t2_head_key", result_key, 0);
    @(posedge clk); #1 result_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_valid_empty", 256'(result_valid), 0);
    chk("t2_key_empty", result_key, 0);
    chk("t2_sb_empty", 256'(exp_q.size()), 0);

    // 3: first_only with every key matching
    expect_res(256'd100, 2'd0);
    launch(256'd100, 32'd50, 256'd0, 256'd0, 1'b1);
    wait_done(30, "t3");
    chk("t3_keys", 256'(keys_tested), 12);
    chk("t3_drop", 256'(drop_count), 0);
    chk("t3_ovf", 256'(overflow), 0);
    chk("t3_sb_empty", 256'(exp_q.size()), 0);

    // 4: key wrap around 2^256
    expect_res(256'd1, 2'd3);
    launch(ONES - 256'd1, 32'd1, C ^ 256'd1, ONES, 1'b0);
    wait_done(20, "t4");
    chk("t4_keys", 256'(keys_tested), 4);
    chk("t4_sb_empty", 256'(exp_q.size()), 0);

    // 5: stop in the third SEARCH cycle, start while busy ignored
    launch(256'd0, 32'd1000, C ^ 256'd5000, ONES, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_done(5, "t5");
    chk("t5_keys", 256'(keys_tested), 8);
    d0 = done_cnt;
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_idle_stop_busy", 256'(busy), 0);
    chk("t5_idle_stop_done", 256'(done_cnt), 256'(d0));

    // 6: asynchronous reset mid-search with stalled FIFO
    result_ready = 1'b0;
    launch(256'd0, 32'd1000, 256'd0, 256'd0, 1'b0);
    k = 0;
    while (!result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t6_fifo_filling", 256'(result_valid), 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", 256'(busy), 0);
    chk("t6_done", 256'(done), 0);
    chk("t6_valid", 256'(result_valid), 0);
    chk("t6_keys", 256'(keys_tested), 0);
    chk("t6_drop", 256'(drop_count), 0);
    chk("t6_ovf", 256'(overflow), 0);
    @(posedge clk); #1 reset_n = 1'b1; result_ready = 1'b1;
    expect_res(256'd1, 2'd3);
    launch(ONES - 256'd1, 32'd1, C ^ 256'd1, ONES, 1'b0);
    wait_done(20, "t6_restart");
    chk("t6_restart_keys", 256'(keys_tested), 4);
    chk("t6_sb_empty", 256'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vanity_search_engine.md
Name: vanity_search_engine

Overview:
- Parametrised successor to the fixed 4-pipeline vanity wallet search.
- Scans a programmable key range across NUM_LANES parallel lanes, each through a HASH_LATENCY-deep hash pipeline, and compares hashes against a masked pattern.
- Queues matches in a result FIFO with a valid/ready handshake; supports abort and a stop-on-first-match mode.
- Sits between the host control registers and the key-export logic.

Parameters:
NUM_LANES, 4, parallel keys tested per round (power of 2, 1..16)
KEY_WIDTH, 256, private key width; equals HASH_WIDTH
HASH_WIDTH, 256, hash width; multiple of 32
HASH_LATENCY, 2, register stages in the hash pipeline (>=1)
RESULT_DEPTH, 4, result FIFO entries (power of 2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  launch a search; honoured only in IDLE
stop  in  1  abort request; honoured only in SEARCH
first_only  in  1  stop issuing after the first pushed result; sampled on start
base_key  in  KEY_WIDTH  first key; sampled on start
num_rounds  in  32  rounds to issue (keys = num_rounds*NUM_LANES); sampled on start
pattern  in  HASH_WIDTH  target hash bits; sampled on start
pattern_mask  in  HASH_WIDTH  1 = bit compared; sampled on start
busy  out  1  high in SEARCH or DRAIN
done  out  1  one-cycle pulse in DONE
result_valid  out  1  FIFO non-empty
result_ready  in  1  consumer accepts head entry
result_key  out  KEY_WIDTH  head entry key
result_lane  out  $clog2(NUM_LANES) (min 1)  head entry lane
keys_tested  out  32  keys evaluated since last start, wraps mod 2^32
drop_count  out  16  matches not queued since last start, saturating
overflow  out  1  sticky: set when a counted drop occurs; cleared on start

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, pipeline valids 0, FIFO empty, all outputs 0.
- Hash stub: hash(k) = k XOR C, where C is 32'hDEADBEEF replicated HASH_WIDTH/32 times.
- Match rule: stage valid AND ((hash XOR pattern) AND pattern_mask) == 0. A mask of 0 matches every valid key.
- Key numbering: lane i in round r tests base_key + r*NUM_LANES + i, mod 2^KEY_WIDTH. Wrap is silent.
- IDLE:
  - start=1: latch inputs, clear round_cnt, keys_tested, drop_count and overflow; go to SEARCH next cycle.
  - start and stop together: start wins.
  - FIFO contents are kept across searches.
- SEARCH:
  - If round_cnt < num_rounds and no halt condition: issue one round (all lanes valid into stage 0), round_cnt++.
  - Otherwise go to DRAIN; no further issue.
  - Halt conditions: stop=1 in this cycle, or first_only with a result already pushed.
  - num_rounds=0 gives SEARCH for 1 cycle, then DRAIN.
- DRAIN: wait until every pipeline stage valid is 0 (HASH_LATENCY+1 cycles worst case), then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: a round issued in cycle c is evaluated (match compare) in cycle c+HASH_LATENCY. A push there makes result_valid visible at c+HASH_LATENCY+1.
- keys_tested increases by NUM_LANES per valid round at evaluation.
- Push policy: at most one push per cycle, from the lowest-index matching lane.
  - Other matches in the same cycle, or any match while the FIFO is full with no pop, count as drops (drop_count++ per lane, saturating at 16'hFFFF) and set overflow.
  - Full FIFO with a pop in the same cycle: the push is accepted.
- first_only:
  - After the first push, later matches are discarded silently: no drop count, no overflow.
  - Issue ceases from the cycle after the push.
- FIFO handshake:
  - Pop when result_valid & result_ready.
  - Head entry stays stable while valid & !ready.
  - result_key and result_lane are 0 when the FIFO is empty.
- stop during DRAIN or DONE: ignored. start while busy: ignored.
- Rounds in flight at stop are still evaluated and may push.
- Reset mid-operation: immediate return to IDLE, FIFO flushed, counters zeroed.

Test Plan:
1. base=0, num_rounds=8, mask=all-ones, pattern=C^5, first_only=0 -> exactly one result: key=5, lane=1; keys_tested=32; drop_count=0; one done pulse; busy low after done.
2. base=0, num_rounds=3, mask=0, result_ready=0 -> FIFO holds keys 0,4,8 (lane 0); drop_count=9; overflow=1. Then result_ready=1 -> 3 pops in order, result_valid drops.
3. base=100, num_rounds=50, mask=0, first_only=1, result_ready=1 -> single result key=100, lane=0; keys_tested=12; drop_count=0; done pulse.
4. base=2^256-2, num_rounds=1, mask=all-ones, pattern=C^1 -> result key=1, lane=3 (wrap verified); keys_tested=4.
5. num_rounds=1000, stop pulsed in the 3rd SEARCH cycle -> 2 rounds issued; keys_tested=8; done within HASH_LATENCY+3 cycles of stop. Also: start while busy ignored; stop in IDLE ignored.
6. reset_n dropped mid-SEARCH with 2 FIFO entries -> busy, done, result_valid, keys_tested, drop_count and overflow are 0 asynchronously. A subsequent start works normally.
